watch_time_counter: RTL and testbench
=====================================

Name: watch_time_counter

Overview:
Timekeeping core of the digital watch. Consumes the slow square-wave clock from the clock-divider stage as a data input in the system clock domain. Rising edges of that square wave are converted into one-second tick enables. Maintains 24-hour HH:MM:SS in BCD, with a small set-mode FSM so the user can adjust hours and minutes. Outputs feed the seven-segment display driver.

Parameters:
EDGES_PER_SEC, 1, rising edges of slow_clk per second increment (legal values 1..255)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
slow_clk  input  1  divider square-wave output; asynchronous to clk for timing purposes
mode_btn  input  1  single-cycle pulse, already debounced upstream
inc_btn  input  1  single-cycle pulse, already debounced upstream
hr_tens  output  2  hours tens digit, 0..2
hr_ones  output  4  hours ones digit, 0..9
min_tens  output  3  minutes tens digit, 0..5
min_ones  output  4  minutes ones digit, 0..9
sec_tens  output  3  seconds tens digit, 0..5
sec_ones  output  4  seconds ones digit, 0..9
set_mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
sec_pulse  output  1  one-cycle strobe when seconds advance in RUN

Behaviour:
- Reset (async assert, sync release):
  - all digits 0 (00:00:00), set_mode=RUN, sec_pulse=0, prescaler=0.
  - Both synchronizer flops and the edge-history flop reset to 1, so a static slow_clk level at reset release never produces a tick.
- Edge detect:
  - slow_clk passes through a 2-flop synchronizer.
  - edge = sync_q & ~hist_q.
  - Latency: slow_clk rise to edge pulse is 2-3 clk cycles.
- Prescaler (8-bit), counts edges only in RUN:
  - If count == EDGES_PER_SEC-1: count <= 0 and assert the second tick.
  - Otherwise count <= count+1.
- Tick (RUN only) advances time in the following cycle:
  - sec_pulse=1 for exactly that cycle, aligned with the digit update.
  - Each digit wraps independently: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 carries to hours.
  - Hours are treated as 00..23: 09->10, 19->20, 23->00.
  - 23:59:59 -> 00:00:00 in a single cycle.
- FSM, advanced by mode_btn: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR: seconds cleared to 00, prescaler cleared.
  - In SET states, ticks are ignored and the prescaler is held, but the edge detector keeps running so no stale edge is applied on exit.
- inc_btn:
  - SET_HOUR: hours +1, 23->00, no carry out.
  - SET_MIN: minutes +1, 59->00, no carry into hours.
  - RUN: ignored.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode change wins, inc dropped.
  - Tick and mode_btn (RUN->SET_HOUR) in the same cycle: the seconds clear wins and the tick is discarded; sec_pulse stays 0.
- Reset mid-count or mid-set: immediate return to 00:00:00 RUN.
- Digits never take values outside the ranges listed in Ports.

Decomposition:
- Package watch_pkg holds:
  - mode encodings MODE_RUN=2'b00, MODE_SET_HOUR=2'b01, MODE_SET_MIN=2'b10 (2'b11 is illegal; on entry go to RUN).
  - BCD limit constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, HR_MAX_TENS=2, HR_MAX_ONES_AT_2=3.
- Sub-module slow_edge_sync: synchronizer plus rising-edge detector, reset-to-1 semantics, output edge_pulse. It is reusable for the button inputs later.

Test Plan:
- Reset with slow_clk held high, release rst_n, hold 100 cycles -> no sec_pulse, time stays 00:00:00.
- EDGES_PER_SEC=1, 5 slow_clk rising edges -> exactly 5 sec_pulse strobes, sec_ones=5, each strobe 3-4 clk after its slow_clk rise.
- Preset time via set mode to 23:59, apply 60 edges -> passes 23:59:59, then reads 00:00:00; check hr_tens=0 and hr_ones=0 on the final tick.
- mode_btn once, inc_btn 25 times -> set_mode=01, hours 01 (wraps 23->00), seconds 00. mode_btn, inc_btn 61 times -> minutes 01, hours unchanged. mode_btn -> RUN.
- mode_btn and inc_btn in the same cycle from RUN -> set_mode=01, hours unchanged. In SET_HOUR, slow_clk edges -> no time change, no sec_pulse.
- EDGES_PER_SEC=4, 7 edges -> 1 sec_pulse, prescaler=3. Assert rst_n low mid-sequence -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and limits for the watch timekeeping core.
// Holds the set-mode encodings, BCD digit limits and the hour/minute step helpers.
package watch_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'b00,
      MODE_SET_HOUR = 2'b01,
      MODE_SET_MIN  = 2'b10
   } mode_t;

   localparam logic [2:0] SEC_TENS_MAX     = 3'd5;
   localparam logic [2:0] MIN_TENS_MAX     = 3'd5;
   localparam logic [1:0] HR_MAX_TENS      = 2'd2;
   localparam logic [3:0] HR_MAX_ONES_AT_2 = 4'd3;

   typedef struct packed {
      logic [1:0] tens;
      logic [3:0] ones;
   } hour_t;

   typedef struct packed {
      logic [2:0] tens;
      logic [3:0] ones;
   } min_t;

   // Hours run 00..23; the ones digit only reaches 3 when the tens digit is 2.
   function automatic hour_t next_hour(input hour_t h);
      hour_t n;
      n = h;
      if (h.tens == HR_MAX_TENS && h.ones == HR_MAX_ONES_AT_2) begin
         n.tens = 2'd0;
         n.ones = 4'd0;
      end else if (h.ones == 4'd9) begin
         n.tens = h.tens + 2'd1;
         n.ones = 4'd0;
      end else begin
         n.ones = h.ones + 4'd1;
      end
      return n;
   endfunction

   function automatic logic min_at_max(input min_t m);
      return (m.tens == MIN_TENS_MAX) && (m.ones == 4'd9);
   endfunction

   function automatic min_t next_min(input min_t m);
      min_t n;
      n = m;
      if (min_at_max(m)) begin
         n.tens = 3'd0;
         n.ones = 4'd0;
      end else if (m.ones == 4'd9) begin
         n.tens = m.tens + 3'd1;
         n.ones = 4'd0;
      end else begin
         n.ones = m.ones + 4'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/slow_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// All three flops reset high so a level that is already high at reset release never looks like an edge.
module slow_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic edge_pulse
);

   logic sync_a;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= 1'b1;
      end else begin
         sync_a <= level;
         sync_q <= sync_a;
         hist_q <= sync_q;
      end
   end

   assign edge_pulse = sync_q & ~hist_q;

endmodule

// File: rtl/watch_time_counter.sv
// 24-hour BCD timekeeping core with a RUN / SET_HOUR / SET_MIN adjust mode.
// Rising edges of the divider square wave are prescaled into one-second ticks.
module watch_time_counter
   import watch_pkg::*;
#(
   parameter int EDGES_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       slow_clk,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [1:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [2:0] min_tens,
   output logic [3:0] min_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [1:0] set_mode,
   output logic       sec_pulse
);

   localparam logic [7:0] PRESCALE_LAST = 8'(EDGES_PER_SEC - 1);

   logic       slow_edge;
   logic [7:0] prescaler;
   logic       tick_q;
   mode_t      mode;
   hour_t      hours;
   min_t       mins;
   logic [2:0] secs_tens;
   logic [3:0] secs_ones;

   slow_edge_sync u_slow_edge_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .level      (slow_clk),
      .edge_pulse (slow_edge)
   );

   // Leaving RUN clears the count so a partial second is never carried across an adjustment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= 8'd0;
         tick_q    <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (mode == MODE_RUN) begin
            if (mode_btn) begin
               prescaler <= 8'd0;
            end else if (slow_edge) begin
               if (prescaler == PRESCALE_LAST) begin
                  prescaler <= 8'd0;
                  tick_q    <= 1'b1;
               end else begin
                  prescaler <= prescaler + 8'd1;
               end
            end
         end
      end
   end

   // A mode press always beats a pending tick or an increment in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode      <= MODE_RUN;
         hours     <= '0;
         mins      <= '0;
         secs_tens <= 3'd0;
         secs_ones <= 4'd0;
         sec_pulse <= 1'b0;
      end else begin
         sec_pulse <= 1'b0;
         case (mode)
            MODE_RUN: begin
               if (mode_btn) begin
                  mode      <= MODE_SET_HOUR;
                  secs_tens <= 3'd0;
                  secs_ones <= 4'd0;
               end else if (tick_q) begin
                  sec_pulse <= 1'b1;
                  if (secs_ones != 4'd9) begin
                     secs_ones <= secs_ones + 4'd1;
                  end else begin
                     secs_ones <= 4'd0;
                     if (secs_tens != SEC_TENS_MAX) begin
                        secs_tens <= secs_tens + 3'd1;
                     end else begin
                        secs_tens <= 3'd0;
                        mins      <= next_min(mins);
                        if (min_at_max(mins)) begin
                           hours <= next_hour(hours);
                        end
                     end
                  end
               end
            end
            MODE_SET_HOUR: begin
               if (mode_btn) begin
                  mode <= MODE_SET_MIN;
               end else if (inc_btn) begin
                  hours <= next_hour(hours);
               end
            end
            MODE_SET_MIN: begin
               if (mode_btn) begin
                  mode <= MODE_RUN;
               end else if (inc_btn) begin
                  mins <= next_min(mins);
               end
            end
            default: mode <= MODE_RUN;
         endcase
      end
   end

   assign hr_tens  = hours.tens;
   assign hr_ones  = hours.ones;
   assign min_tens = mins.tens;
   assign min_ones = mins.ones;
   assign sec_tens = secs_tens;
   assign sec_ones = secs_ones;
   assign set_mode = mode;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: two instances (1 and 4 edges per second) share stimulus and are
// compared every cycle against a time-of-day model kept as plain integer hours/minutes/seconds.
module tb_watch_time_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic slow_clk = 1'b1;
   logic mode_btn = 1'b0;
   logic inc_btn = 1'b0;

   logic [1:0] hr_tens [2];
   logic [3:0] hr_ones [2];
   logic [2:0] min_tens [2];
   logic [3:0] min_ones [2];
   logic [2:0] sec_tens [2];
   logic [3:0] sec_ones [2];
   logic [1:0] set_mode [2];
   logic       sec_pulse [2];

   int checks = 0;
   int failures = 0;
   int pulses [2];

   int eps [2] = '{1, 4};
   int m_h [2];
   int m_m [2];
   int m_s [2];
   int m_mode [2];
   int m_count [2];
   int m_tick [2];
   int m_pulse [2];
   bit h1, h2, h3;

   always #5 clk = ~clk;

   watch_time_counter #(.EDGES_PER_SEC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .hr_tens(hr_tens[0]), .hr_ones(hr_ones[0]), .min_tens(min_tens[0]), .min_ones(min_ones[0]),
      .sec_tens(sec_tens[0]), .sec_ones(sec_ones[0]), .set_mode(set_mode[0]), .sec_pulse(sec_pulse[0])
   );

   watch_time_counter #(.EDGES_PER_SEC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .hr_tens(hr_tens[1]), .hr_ones(hr_ones[1]), .min_tens(min_tens[1]), .min_ones(min_ones[1]),
      .sec_tens(sec_tens[1]), .sec_ones(sec_ones[1]), .set_mode(set_mode[1]), .sec_pulse(sec_pulse[1])
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, expected, $time);
      end
   endtask

   function automatic logic [31:0] dutAll(input int k);
      return {9'd0, hr_tens[k], hr_ones[k], min_tens[k], min_ones[k],
              sec_tens[k], sec_ones[k], set_mode[k], sec_pulse[k]};
   endfunction

   function automatic logic [31:0] dutTime(input int k);
      return {12'd0, hr_tens[k], hr_ones[k], min_tens[k], min_ones[k], sec_tens[k], sec_ones[k]};
   endfunction

   function automatic logic [31:0] modelAll(input int k);
      logic [1:0] ht;
      logic [3:0] ho;
      logic [2:0] mt;
      logic [3:0] mo;
      logic [2:0] st;
      logic [3:0] so;
      ht = 2'(m_h[k] / 10);
      ho = 4'(m_h[k] % 10);
      mt = 3'(m_m[k] / 10);
      mo = 4'(m_m[k] % 10);
      st = 3'(m_s[k] / 10);
      so = 4'(m_s[k] % 10);
      return {9'd0, ht, ho, mt, mo, st, so, 2'(m_mode[k]), 1'(m_pulse[k])};
   endfunction

   task automatic resetModel();
      for (int k = 0; k < 2; k++) begin
         m_h[k] = 0; m_m[k] = 0; m_s[k] = 0; m_mode[k] = 0;
         m_count[k] = 0; m_tick[k] = 0; m_pulse[k] = 0;
      end
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
   endtask

   // One clock of the reference: a rise sampled at edge r is counted at r+2 and shows on the digits at r+3.
   task automatic stepModel(input bit mb, input bit ib, input bit sc);
      bit rise;
      int total;
      rise = h2 && !h3;
      h3 = h2; h2 = h1; h1 = sc;
      for (int k = 0; k < 2; k++) begin
         case (m_mode[k])
            0: begin
               if (mb) begin
                  m_mode[k] = 1; m_s[k] = 0; m_count[k] = 0; m_tick[k] = 0; m_pulse[k] = 0;
               end else begin
                  m_pulse[k] = m_tick[k];
                  if (m_tick[k] != 0) begin
                     total = (m_h[k] * 3600 + m_m[k] * 60 + m_s[k] + 1) % 86400;
                     m_h[k] = total / 3600;
                     m_m[k] = (total / 60) % 60;
                     m_s[k] = total % 60;
                  end
                  m_tick[k] = 0;
                  if (rise) begin
                     m_count[k]++;
                     if (m_count[k] == eps[k]) begin
                        m_count[k] = 0;
                        m_tick[k] = 1;
                     end
                  end
               end
            end
            1: begin
               m_pulse[k] = 0; m_tick[k] = 0;
               if (mb) m_mode[k] = 2;
               else if (ib) m_h[k] = (m_h[k] + 1) % 24;
            end
            default: begin
               m_pulse[k] = 0; m_tick[k] = 0;
               if (mb) m_mode[k] = 0;
               else if (ib) m_m[k] = (m_m[k] + 1) % 60;
            end
         endcase
      end
   endtask

   // Called at a falling edge: drive inputs for the next rising edge, then compare after it.
   task automatic applyStimulus(input bit mb, input bit ib, input bit sc);
      mode_btn = mb;
      inc_btn = ib;
      slow_clk = sc;
      stepModel(mb, ib, sc);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("cycle_n%0d", eps[k]), dutAll(k), modelAll(k));
         if (sec_pulse[k] === 1'b1) pulses[k]++;
      end
   endtask

   task automatic slowEdges(input int n, input int lo, input int hi);
      for (int e = 0; e < n; e++) begin
         repeat (lo) applyStimulus(1'b0, 1'b0, 1'b0);
         repeat (hi) applyStimulus(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, slow_clk);
   endtask

   task automatic pressInc(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, slow_clk);
         applyStimulus(1'b0, 1'b0, slow_clk);
      end
   endtask

   task automatic asyncReset();
      #2;
      rst_n = 1'b0;
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      slow_clk = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) checkOutput($sformatf("async_reset_n%0d", eps[k]), dutAll(k), 32'd0);
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int run_len;
      bit lvl;
      resetModel();
      pulses = '{0, 0};
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) checkOutput($sformatf("reset_n%0d", eps[k]), dutAll(k), 32'd0);
      rst_n = 1'b1;

      idle(100);
      checkOutput("idle_no_pulse", 32'(pulses[0] + pulses[1]), 32'd0);

      pulses = '{0, 0};
      slowEdges(5, 2, 2);
      idle(4);
      checkOutput("five_edges_pulses", 32'(pulses[0]), 32'd5);
      checkOutput("five_edges_sec_ones", 32'(sec_ones[0]), 32'd5);
      checkOutput("five_edges_n4_pulses", 32'(pulses[1]), 32'd1);

      applyStimulus(1'b1, 1'b0, 1'b1);
      pressInc(23);
      applyStimulus(1'b1, 1'b0, 1'b1);
      pressInc(59);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("preset_2359", dutTime(0), {12'd0, 2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0});

      pulses = '{0, 0};
      slowEdges(59, 1, 2);
      idle(4);
      checkOutput("time_235959", dutTime(0), {12'd0, 2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9});
      slowEdges(1, 1, 2);
      idle(4);
      checkOutput("rollover_hr_tens", 32'(hr_tens[0]), 32'd0);
      checkOutput("rollover_hr_ones", 32'(hr_ones[0]), 32'd0);
      checkOutput("rollover_time", dutTime(0), 32'd0);
      checkOutput("rollover_pulses", 32'(pulses[0]), 32'd60);

      applyStimulus(1'b1, 1'b0, 1'b1);
      pressInc(25);
      checkOutput("set_hour_mode", 32'(set_mode[0]), 32'd1);
      checkOutput("set_hour_wrap", dutTime(0), {12'd0, 2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0});
      applyStimulus(1'b1, 1'b0, 1'b1);
      pressInc(61);
      checkOutput("set_min_wrap", dutTime(0), {12'd0, 2'd0, 4'd1, 3'd0, 4'd1, 3'd0, 4'd0});
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("back_to_run", 32'(set_mode[0]), 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("mode_inc_same_mode", 32'(set_mode[0]), 32'd1);
      checkOutput("mode_inc_same_hours", dutTime(0), {12'd0, 2'd0, 4'd1, 3'd0, 4'd1, 3'd0, 4'd0});
      pulses = '{0, 0};
      slowEdges(6, 2, 2);
      checkOutput("set_hour_edges_pulses", 32'(pulses[0] + pulses[1]), 32'd0);
      checkOutput("set_hour_edges_time", dutTime(0), {12'd0, 2'd0, 4'd1, 3'd0, 4'd1, 3'd0, 4'd0});
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      idle(4);

      // Rise sampled at r, tick pending after r+2, mode press lands on r+3.
      pulses = '{0, 0};
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      idle(3);
      checkOutput("tick_vs_mode_pulse", 32'(pulses[0]), 32'd0);
      checkOutput("tick_vs_mode_state", 32'(set_mode[0]), 32'd1);
      checkOutput("tick_vs_mode_secs", 32'({sec_tens[0], sec_ones[0]}), 32'd0);

      asyncReset();
      pulses = '{0, 0};
      slowEdges(7, 2, 2);
      idle(4);
      checkOutput("n4_seven_edges", 32'(pulses[1]), 32'd1);
      slowEdges(1, 2, 2);
      idle(4);
      checkOutput("n4_eighth_edge", 32'(pulses[1]), 32'd2);
      slowEdges(2, 2, 2);
      asyncReset();
      pulses = '{0, 0};
      idle(20);
      checkOutput("post_reset_quiet", 32'(pulses[0] + pulses[1]), 32'd0);

      lvl = slow_clk;
      run_len = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run_len == 0) begin
            lvl = ~lvl;
            run_len = $urandom_range(1, 4);
         end
         run_len--;
         applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0), lvl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
